// File: rtl/alu_multibyte_seq.sv
// Multi-byte arithmetic sequencer: runs an external 8-bit ALU once per byte,
// chaining carry between bytes and writing each result byte back to scratch RAM.
module alu_multibyte_seq #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 4
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [2:0]        op_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [ADDR_W-1:0] a_base_i,
  input  logic [ADDR_W-1:0] b_base_i,
  input  logic [ADDR_W-1:0] d_base_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              c_out_o,
  output logic              z_out_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [7:0]        mem_wdata_o,
  input  logic [7:0]        mem_rdata_i,
  output logic [3:0]        alu_sel_o,
  output logic [7:0]        alu_a_o,
  output logic [7:0]        alu_b_o,
  output logic              alu_cin_o,
  input  logic [7:0]        alu_result_i,
  input  logic              alu_c_i,
  input  logic              alu_z_i
);

  typedef enum logic [2:0] {S_IDLE, S_RD_A, S_RD_B, S_EXEC, S_FIN} state_t;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_CMP = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_LSL = 3'd6;
  localparam logic [2:0] OP_LSR = 3'd7;

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  i_q, i_d;
  logic [ADDR_W-1:0] a_base_q, a_base_d;
  logic [ADDR_W-1:0] b_base_q, b_base_d;
  logic [ADDR_W-1:0] d_base_q, d_base_d;
  logic [7:0]        ar_q, ar_d;
  logic              cr_q, cr_d;
  logic              za_q, za_d;
  logic              c_out_q, c_out_d;
  logic              z_out_q, z_out_d;

  logic [LEN_W-1:0]  k_w;
  logic [ADDR_W-1:0] offset_w;
  logic              first_w;
  logic              last_w;
  logic [3:0]        sel_w;

  // LSR walks the word MSB first so the shifted-out bit carries downward.
  assign k_w      = (op_q == OP_LSR) ? (len_q - LEN_ONE - i_q) : i_q;
  assign offset_w = ADDR_W'(k_w);
  assign first_w  = (i_q == '0);
  assign last_w   = (i_q == (len_q - LEN_ONE));

  always_comb begin
    sel_w = 4'd0;
    case (op_q)
      OP_ADD:  sel_w = first_w ? 4'd0 : 4'd1;
      OP_SUB:  sel_w = first_w ? 4'd2 : 4'd3;
      OP_CMP:  sel_w = first_w ? 4'd2 : 4'd3;
      OP_AND:  sel_w = 4'd5;
      OP_OR:   sel_w = 4'd6;
      OP_XOR:  sel_w = 4'd7;
      OP_LSL:  sel_w = 4'd9;
      OP_LSR:  sel_w = 4'd10;
      default: sel_w = 4'd0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    len_d      = len_q;
    i_d        = i_q;
    a_base_d   = a_base_q;
    b_base_d   = b_base_q;
    d_base_d   = d_base_q;
    ar_d       = ar_q;
    cr_d       = cr_q;
    za_d       = za_q;
    c_out_d    = c_out_q;
    z_out_d    = z_out_q;
    mem_addr_o = '0;
    mem_we_o   = 1'b0;
    alu_sel_o  = 4'd0;
    alu_cin_o  = 1'b0;
    done_o     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (len_i != '0) begin
            op_d     = op_i;
            len_d    = len_i;
            a_base_d = a_base_i;
            b_base_d = b_base_i;
            d_base_d = d_base_i;
            i_d      = '0;
            cr_d     = 1'b0;
            za_d     = 1'b1;
            state_d  = S_RD_A;
          end else begin
            c_out_d = 1'b0;
            z_out_d = 1'b1;
            state_d = S_FIN;
          end
        end
      end
      S_RD_A: begin
        mem_addr_o = a_base_q + offset_w;
        alu_sel_o  = sel_w;
        alu_cin_o  = cr_q;
        state_d    = S_RD_B;
      end
      S_RD_B: begin
        mem_addr_o = b_base_q + offset_w;
        alu_sel_o  = sel_w;
        alu_cin_o  = cr_q;
        ar_d       = mem_rdata_i;
        state_d    = S_EXEC;
      end
      S_EXEC: begin
        mem_addr_o = d_base_q + offset_w;
        mem_we_o   = (op_q != OP_CMP);
        alu_sel_o  = sel_w;
        alu_cin_o  = cr_q;
        cr_d       = alu_c_i;
        za_d       = za_q & alu_z_i;
        if (last_w) begin
          // Flags are loaded on entry to FIN so they are already valid with DONE.
          c_out_d = alu_c_i;
          z_out_d = za_q & alu_z_i;
          state_d = S_FIN;
        end else begin
          i_d     = i_q + LEN_ONE;
          state_d = S_RD_A;
        end
      end
      S_FIN: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      op_q     <= OP_ADD;
      len_q    <= '0;
      i_q      <= '0;
      a_base_q <= '0;
      b_base_q <= '0;
      d_base_q <= '0;
      ar_q     <= 8'd0;
      cr_q     <= 1'b0;
      za_q     <= 1'b1;
      c_out_q  <= 1'b0;
      z_out_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      len_q    <= len_d;
      i_q      <= i_d;
      a_base_q <= a_base_d;
      b_base_q <= b_base_d;
      d_base_q <= d_base_d;
      ar_q     <= ar_d;
      cr_q     <= cr_d;
      za_q     <= za_d;
      c_out_q  <= c_out_d;
      z_out_q  <= z_out_d;
    end
  end

  assign busy_o      = (state_q != S_IDLE);
  assign c_out_o     = c_out_q;
  assign z_out_o     = z_out_q;
  assign mem_wdata_o = alu_result_i;
  assign alu_a_o     = ar_q;
  assign alu_b_o     = mem_rdata_i;

endmodule

// File: tb/tb_alu_multibyte_seq.sv
// Bench for alu_multibyte_seq: behavioral ALU and scratch RAM, word-level
// reference model, and a scoreboard of the expected RAM access trace.
module tb_alu_multibyte_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] op_in = 3'd0;
  logic [3:0] len_in = 4'd0;
  logic [7:0] a_base = 8'd0, b_base = 8'd0, d_base = 8'd0;
  logic       busy, done, c_out, z_out, mem_we, alu_cin, alu_c, alu_z;
  logic [7:0] mem_addr, mem_wdata, mem_rdata, alu_a, alu_b, alu_result;
  logic [3:0] alu_sel;

  logic [7:0] mem [256];
  logic       tb_we = 1'b0;
  logic [7:0] tb_addr = 8'd0, tb_wdata = 8'd0;
  logic [8:0] alu_r9;
  logic [8:0] trace_q [$];
  bit         mon_en = 1'b1;
  int         n_err = 0;
  int         n_chk = 0;

  always #5 clk = ~clk;

  alu_multibyte_seq #(.ADDR_W(8), .LEN_W(4)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .op_i(op_in), .len_i(len_in),
    .a_base_i(a_base), .b_base_i(b_base), .d_base_i(d_base),
    .busy_o(busy), .done_o(done), .c_out_o(c_out), .z_out_o(z_out),
    .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .alu_sel_o(alu_sel), .alu_a_o(alu_a), .alu_b_o(alu_b),
    .alu_cin_o(alu_cin), .alu_result_i(alu_result), .alu_c_i(alu_c), .alu_z_i(alu_z)
  );

  always_comb begin
    alu_r9 = 9'd0;
    case (alu_sel)
      4'd0:  alu_r9 = {1'b0, alu_a} + {1'b0, alu_b};
      4'd1:  alu_r9 = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};
      4'd2:  alu_r9 = {1'b0, alu_a} - {1'b0, alu_b};
      4'd3:  alu_r9 = {1'b0, alu_a} - {1'b0, alu_b} - {8'd0, alu_cin};
      4'd5:  alu_r9 = {1'b0, alu_a & alu_b};
      4'd6:  alu_r9 = {1'b0, alu_a | alu_b};
      4'd7:  alu_r9 = {1'b0, alu_a ^ alu_b};
      4'd9:  alu_r9 = {alu_a[7], alu_a[6:0], alu_cin};
      4'd10: alu_r9 = {alu_a[0], alu_cin, alu_a[7:1]};
      default: alu_r9 = 9'd0;
    endcase
  end
  assign alu_result = alu_r9[7:0];
  assign alu_c      = alu_r9[8];
  assign alu_z      = (alu_r9[7:0] == 8'd0);

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    else if (tb_we) mem[tb_addr] <= tb_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Every busy cycle before DONE must match the next expected {we, addr}.
  always @(negedge clk) begin
    if (mon_en && rst_n && busy && !done) begin
      if (trace_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL trace_extra: unexpected access addr 0x%0h we %0b", mem_addr, mem_we);
      end else begin
        logic [8:0] e;
        e = trace_q.pop_front();
        check_val("trace_addr", {56'd0, mem_addr}, {56'd0, e[7:0]});
        check_val("trace_we", {63'd0, mem_we}, {63'd0, e[8]});
      end
    end
  end

  task automatic preload(input logic [7:0] base, input int len, input logic [63:0] val);
    for (int j = 0; j < len; j++) begin
      @(negedge clk);
      tb_we = 1'b1;
      tb_addr = base + 8'(j);
      tb_wdata = val[8*j +: 8];
    end
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  function automatic logic [63:0] read_word(input logic [7:0] base, input int len);
    logic [63:0] w;
    w = 64'd0;
    for (int j = 0; j < len; j++) w[8*j +: 8] = mem[base + 8'(j)];
    return w;
  endfunction

  task automatic run_cmd(input logic [2:0] op, input int len, input logic [7:0] ab,
                         input logic [7:0] bb, input logic [7:0] db, input bit mid);
    logic [63:0] aw, bw, dw, sum, pre, mask;
    logic ec, ez;
    logic [7:0] k;
    int cyc;
    aw = read_word(ab, len);
    bw = read_word(bb, len);
    pre = read_word(db, len);
    mask = (64'd1 << (8 * len)) - 64'd1;
    dw = 64'd0;
    ec = 1'b0;
    if (len != 0) begin
      case (op)
        3'd0: begin sum = aw + bw; ec = sum[8*len]; dw = sum & mask; end
        3'd1, 3'd2: begin dw = (aw - bw) & mask; ec = (aw < bw); end
        3'd3: dw = aw & bw;
        3'd4: dw = aw | bw;
        3'd5: dw = aw ^ bw;
        3'd6: begin ec = aw[8*len-1]; dw = (aw << 1) & mask; end
        default: begin ec = aw[0]; dw = aw >> 1; end
      endcase
    end
    ez = (dw == 64'd0);
    for (int j = 0; j < len; j++) begin
      k = (op == 3'd7) ? 8'(len - 1 - j) : 8'(j);
      trace_q.push_back({1'b0, ab + k});
      trace_q.push_back({1'b0, bb + k});
      trace_q.push_back({(op != 3'd2), db + k});
    end
    @(negedge clk);
    start = 1'b1; op_in = op; len_in = 4'(len);
    a_base = ab; b_base = bb; d_base = db;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 200) begin
      if (mid && cyc == 4) begin
        start = 1'b1; op_in = 3'd5; len_in = 4'd1;
        a_base = 8'hE0; b_base = 8'hE1; d_base = 8'hE2;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check_val("done_cycle", 64'(cyc), 64'(3 * len + 1));
    check_val("c_out", {63'd0, c_out}, {63'd0, ec});
    check_val("z_out", {63'd0, z_out}, {63'd0, ez});
    @(negedge clk);
    check_val("done_pulse", {63'd0, done}, 64'd0);
    check_val("busy_after", {63'd0, busy}, 64'd0);
    check_val("trace_left", 64'(trace_q.size()), 64'd0);
    trace_q.delete();
    if (len != 0)
      check_val("dest", read_word(db, len), (op == 3'd2) ? pre : dw);
    $display("cmd op=%0d len=%0d A=0x%0h B=0x%0h -> D=0x%0h C=%0b Z=%0b cycles=%0d",
             op, len, aw, bw, read_word(db, len), c_out, z_out, cyc);
  endtask

  initial begin
    #1;
    check_val("rst_busy", {63'd0, busy}, 64'd0);
    check_val("rst_done", {63'd0, done}, 64'd0);
    check_val("rst_flags", {62'd0, c_out, z_out}, 64'd0);
    check_val("rst_we", {63'd0, mem_we}, 64'd0);
    check_val("rst_ar", {56'd0, alu_a}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    preload(8'h10, 2, 64'h01FF); preload(8'h20, 2, 64'h0001);
    run_cmd(3'd0, 2, 8'h10, 8'h20, 8'h30, 1'b0);

    preload(8'h11, 1, 64'h10); preload(8'h21, 1, 64'h20); preload(8'h40, 1, 64'h5A);
    run_cmd(3'd2, 1, 8'h11, 8'h21, 8'h40, 1'b0);

    preload(8'h50, 2, 64'h1234); preload(8'h52, 2, 64'h1234);
    run_cmd(3'd1, 2, 8'h50, 8'h52, 8'h54, 1'b0);
    preload(8'h56, 2, 64'h0000); preload(8'h58, 2, 64'h0001);
    run_cmd(3'd1, 2, 8'h56, 8'h58, 8'h5A, 1'b0);

    preload(8'h60, 2, 64'h0103);
    run_cmd(3'd7, 2, 8'h60, 8'h62, 8'h64, 1'b0);
    preload(8'h66, 2, 64'h8001);
    run_cmd(3'd6, 2, 8'h66, 8'h68, 8'h6A, 1'b0);

    preload(8'hFF, 1, 64'hC3); preload(8'h00, 1, 64'h81); preload(8'h70, 2, 64'h0F0F);
    run_cmd(3'd5, 2, 8'hFF, 8'h70, 8'h72, 1'b0);
    run_cmd(3'd0, 0, 8'h10, 8'h20, 8'h30, 1'b0);

    preload(8'h80, 3, 64'hA5F00F); preload(8'h83, 3, 64'h3C3CC3);
    run_cmd(3'd3, 3, 8'h80, 8'h83, 8'h86, 1'b1);
    run_cmd(3'd4, 3, 8'h80, 8'h83, 8'h89, 1'b1);
    preload(8'h8C, 3, 64'hFFFFFF); preload(8'h8F, 3, 64'h000001);
    run_cmd(3'd0, 3, 8'h8C, 8'h8F, 8'h92, 1'b1);

    // Abort a 3-byte ADD in the EXEC cycle of its second byte.
    run_cmd(3'd6, 1, 8'h66 + 8'd1, 8'h68, 8'h6C, 1'b0);
    preload(8'h90, 3, 64'h030201); preload(8'hA0, 3, 64'h010101);
    preload(8'hB0, 3, 64'hEEEEEE);
    mon_en = 1'b0;
    @(negedge clk);
    start = 1'b1; op_in = 3'd0; len_in = 4'd3;
    a_base = 8'h90; b_base = 8'hA0; d_base = 8'hB0;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check_val("pre_abort_we", {63'd0, mem_we}, 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check_val("abort_busy", {63'd0, busy}, 64'd0);
    check_val("abort_done", {63'd0, done}, 64'd0);
    check_val("abort_we", {63'd0, mem_we}, 64'd0);
    check_val("abort_addr", {56'd0, mem_addr}, 64'd0);
    check_val("abort_sel_cin", {59'd0, alu_sel, alu_cin}, 64'd0);
    check_val("abort_flags", {62'd0, c_out, z_out}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int seen;
      seen = 0;
      repeat (8) begin
        @(negedge clk);
        if (done || busy) seen++;
      end
      check_val("abort_no_done", 64'(seen), 64'd0);
    end
    check_val("abort_byte0", {56'd0, mem[8'hB0]}, 64'h02);
    check_val("abort_byte1", {56'd0, mem[8'hB1]}, 64'hEE);
    $display("abort: D0=0x%0h D1=0x%0h", mem[8'hB0], mem[8'hB1]);
    mon_en = 1'b1;
    run_cmd(3'd0, 3, 8'h90, 8'hA0, 8'hB0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_multibyte_seq.md
# alu_multibyte_seq

Multi-byte arithmetic sequencer for the 8-bit ALU. It accepts one command: operation, byte length, and three scratch-RAM base addresses. It then runs the ALU once per byte, chaining carry between bytes, and writes each result byte back to scratch RAM. It sits between the control unit and the ALU/scratch RAM, and owns both the ALU select/operand/carry inputs and the RAM port while busy.

## Interface
- ADDR_W, 8, scratch RAM address width
- LEN_W, 4, command length field width (1..2^LEN_W-1 bytes)

Ports:
- CLK  in  1  system clock, all state changes on rising edge
- RST_N  in  1  asynchronous, active-low reset
- START  in  1  command strobe, sampled only in IDLE
- OP  in  3  0 ADD, 1 SUB, 2 CMP, 3 AND, 4 OR, 5 XOR, 6 LSL, 7 LSR
- LEN  in  LEN_W  operand length in bytes
- A_BASE, B_BASE, D_BASE  in  ADDR_W each  operand A, operand B and destination base addresses
- BUSY  out  1  high from the cycle after START is accepted until DONE
- DONE  out  1  one-cycle completion pulse
- C_OUT, Z_OUT  out  1 each  final carry/borrow and whole-word zero flag, valid while DONE is high, held until next START
- MEM_ADDR  out  ADDR_W  RAM address
- MEM_WE  out  1  RAM write enable
- MEM_WDATA  out  8  RAM write data (= ALU_RESULT)
- MEM_RDATA  in  8  RAM read data, valid one cycle after its address
- ALU_SEL  out  4  ALU operation select
- ALU_A, ALU_B  out  8 each  ALU operands
- ALU_CIN  out  1  ALU carry in
- ALU_RESULT  in  8  ALU result
- ALU_C, ALU_Z  in  1 each  ALU flags

## Operation
- States: IDLE, RD_A, RD_B, EXEC, FIN.
- **IDLE**
  - START=1 with LEN≠0: latch OP, LEN and bases; clear byte index i, carry reg CR and the zero accumulator ZA=1; go to RD_A.
  - START=1 with LEN=0: go directly to FIN with C_OUT=0, Z_OUT=1, no RAM access.
- **RD_A:** MEM_ADDR = A_BASE + k. Go to RD_B.
- **RD_B:** MEM_ADDR = B_BASE + k; latch MEM_RDATA into AR. Go to EXEC.
- **EXEC**
  - ALU_A=AR, ALU_B=MEM_RDATA, ALU_CIN=CR, MEM_ADDR = D_BASE + k.
  - MEM_WE=1 for all ops except CMP.
  - Update CR←ALU_C and ZA←ZA & ALU_Z.
  - If i = LEN-1, go to FIN; otherwise i←i+1 and go to RD_A.
- **FIN:** DONE=1, C_OUT←CR, Z_OUT←ZA. Go to IDLE.
- Byte offset k:
  - k = i for all ops except LSR (LSB first).
  - k = LEN-1-i for LSR (MSB first).
  - All address sums wrap modulo 2^ADDR_W.
- ALU_SEL for the first byte / later bytes:
  - ADD 0/1, SUB 2/3, CMP 2/3
  - AND 5/5, OR 6/6, XOR 7/7
  - LSL 9/9, LSR 10/10
- CR is 0 on the first byte, so LSL shifts a 0 into the LSB and LSR shifts a 0 into the MSB.
- For LSL/LSR the B read still occurs and its data is ignored by the ALU.
- Logic ops: the ALU carry is 0, so C_OUT=0.
- START while BUSY is ignored; latched fields do not change.
- Outputs in IDLE and FIN: MEM_WE=0, MEM_ADDR=0, ALU_SEL=0, ALU_CIN=0. ALU_A=AR and ALU_B=MEM_RDATA in every state.

## Timing
- Reset values (asynchronous): state IDLE, BUSY=0, DONE=0, C_OUT=0, Z_OUT=0, AR=0, CR=0, ZA=1, i=0, MEM_WE=0.
- Per-byte cost: 3 cycles.
- START sampled at edge 0; DONE is high during cycle 3·LEN+1 after that edge.
- LEN=0: DONE is high during cycle 1.
- Next START is accepted in the cycle after DONE (IDLE).
- At most one RAM access per cycle, and a write occurs only in EXEC.
- Reset mid-command: immediate abort to IDLE. Bytes already written stay in RAM, no DONE is issued, flags are cleared.

## Test plan
- 2-byte ADD, A=0x01FF (LSB at A_BASE), B=0x0001 -> D=0x0200, C_OUT=0, Z_OUT=0, DONE at cycle 7, exactly 2 writes.
- 1-byte CMP, A=0x10, B=0x20 -> C_OUT=1, Z_OUT=0, MEM_WE never asserted, RAM unchanged.
- 2-byte SUB, A=B=0x1234 -> D=0x0000, C_OUT=0, Z_OUT=1. Then SUB with A=0x0000, B=0x0001 -> D=0xFFFF, C_OUT=1.
- 2-byte LSR, A=0x0103 -> D=0x0081, C_OUT=1, addresses visited high byte first. 2-byte LSL, A=0x8001 -> D=0x0002, C_OUT=1.
- Address wrap: A_BASE=0xFF, LEN=2 -> reads at 0xFF then 0x00. LEN=0 -> DONE at cycle 1, Z_OUT=1, no RAM access.
- START pulsed mid-command is ignored. RST_N low during the second byte of a 3-byte ADD -> IDLE and all outputs at reset values immediately, no DONE, first byte remains written.
